// File: rtl/request_block_rr_pe.sv
// Round-robin request block for N masters sharing one slave port.
// It arbitrates eligible masters, optionally registers the winning request
// in a one-entry output slice, tracks unanswered requests per master, and
// routes responses back by one-hot ID.
module request_block_rr_pe #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int N_MASTER        = 16,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUT_REG         = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_MASTER-1:0]            data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER-1:0]            data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
  output logic [N_MASTER-1:0]            data_gnt_o,
  output logic                           data_req_o,
  output logic [ADDR_WIDTH-1:0]          data_add_o,
  output logic                           data_wen_o,
  output logic [DATA_WIDTH-1:0]          data_wdata_o,
  output logic [BE_WIDTH-1:0]            data_be_o,
  output logic [ID_WIDTH-1:0]            data_ID_o,
  input  logic                           data_gnt_i,
  input  logic                           data_r_valid_i,
  input  logic [ID_WIDTH-1:0]            data_r_ID_i,
  output logic [N_MASTER-1:0]            data_r_valid_o,
  output logic                           idle_o,
  output logic                           resp_err_o
);

  localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      winner;
  logic                  any_elig;
  logic                  take;
  logic [N_MASTER-1:0]   eligible;
  logic [N_MASTER-1:0]   rsp_hit;
  logic [CNT_W-1:0]      cnt_q   [N_MASTER];
  logic [CNT_W-1:0]      cnt_nxt [N_MASTER];
  logic                  valid_q;
  logic                  valid_nxt;
  logic                  idle_q;
  logic                  err_q;
  logic                  err_nxt;
  logic                  idle_nxt;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ADDR_WIDTH-1:0] win_add;
  logic                  win_wen;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [BE_WIDTH-1:0]   win_be;

  // A master may compete only while it has room for another unanswered request.
  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      eligible[i] = data_req_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
      rsp_hit[i]  = data_r_valid_i && data_r_ID_i[i];
    end
  end

  assign data_r_valid_o = rsp_hit;

  // First eligible master at or above the pointer, wrapping past the top index.
  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and no latch is inferred.
    idx      = 0;
    any_elig = 1'b0;
    winner   = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        winner   = PTR_W'(idx);
      end
    end
  end

  assign win_add   = data_add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wen   = data_wen_i[winner];
  assign win_wdata = data_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign win_be    = data_be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];

  // One-hot ID for the current winner.
  always_comb begin
    win_id         = '0;
    win_id[winner] = 1'b1;
  end

  // Grant goes only to the winner, and only when its request is actually taken.
  always_comb begin
    data_gnt_o         = '0;
    data_gnt_o[winner] = take;
  end

  if (OUT_REG != 0) begin : g_slice
    logic                  slice_ready;
    logic [ADDR_WIDTH-1:0] add_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [ID_WIDTH-1:0]   id_q;

    assign slice_ready = !valid_q || data_gnt_i;
    assign take        = rst_n && any_elig && slice_ready;
    assign valid_nxt   = take ? 1'b1 : (data_gnt_i ? 1'b0 : valid_q);

    // Capture the winning request; held untouched while the slave stalls.
    always_ff @(posedge clk) begin
      // NOTE: the payload registers carry no reset; valid_q alone says whether they mean anything.
      if (take) begin
        add_q   <= win_add;
        wen_q   <= win_wen;
        wdata_q <= win_wdata;
        be_q    <= win_be;
        id_q    <= win_id;
      end
    end

    assign data_req_o   = valid_q;
    assign data_add_o   = add_q;
    assign data_wen_o   = wen_q;
    assign data_wdata_o = wdata_q;
    assign data_be_o    = be_q;
    assign data_ID_o    = id_q;
  end else begin : g_comb
    assign take         = rst_n && any_elig && data_gnt_i;
    assign valid_nxt    = 1'b0;
    assign data_req_o   = rst_n && any_elig;
    assign data_add_o   = win_add;
    assign data_wen_o   = win_wen;
    assign data_wdata_o = win_wdata;
    assign data_be_o    = win_be;
    assign data_ID_o    = win_id;
  end

  // Outstanding counters: a request and its own response in one cycle cancel;
  // a response with nothing outstanding leaves the counter at zero.
  always_comb begin
    err_nxt  = 1'b0;
    idle_nxt = !valid_nxt;
    for (int i = 0; i < N_MASTER; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (take && (winner == PTR_W'(i))) begin
        if (!rsp_hit[i]) cnt_nxt[i] = cnt_q[i] + 1'b1;
      end else if (rsp_hit[i] && (cnt_q[i] != '0)) begin
        cnt_nxt[i] = cnt_q[i] - 1'b1;
      end
      if (rsp_hit[i] && (cnt_q[i] == '0)) err_nxt = 1'b1;
      if (cnt_nxt[i] != '0) idle_nxt = 1'b0;
    end
  end

  // Control state with synchronous active-low reset; the pointer moves past a winner only once it is taken.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
      for (int i = 0; i < N_MASTER; i++) cnt_q[i] <= '0;
    end else begin
      if (take) ptr_q <= (winner == PTR_W'(N_MASTER - 1)) ? '0 : winner + 1'b1;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
      idle_q  <= idle_nxt;
      for (int i = 0; i < N_MASTER; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  assign idle_o     = idle_q;
  assign resp_err_o = err_q;

endmodule

// File: tb/tb_request_block_rr_pe.sv
// Bench for request_block_rr_pe with three masters, a cap of two unanswered
// requests and the registered output slice. Directed scenarios use
// hand-derived constants; a randomized run is compared every cycle against
// a behavioural model of the arbitration, counting and response rules.
module tb_request_block_rr_pe;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int NM   = 3;
  localparam int IW   = 3;
  localparam int MAXO = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NM-1:0]    data_req_i = '0;
  logic [NM*AW-1:0] data_add_i = '0;
  logic [NM-1:0]    data_wen_i = '0;
  logic [NM*DW-1:0] data_wdata_i = '0;
  logic [NM*BW-1:0] data_be_i = '0;
  logic [NM-1:0]    data_gnt_o;
  logic             data_req_o;
  logic [AW-1:0]    data_add_o;
  logic             data_wen_o;
  logic [DW-1:0]    data_wdata_o;
  logic [BW-1:0]    data_be_o;
  logic [IW-1:0]    data_ID_o;
  logic             data_gnt_i = 1'b0;
  logic             data_r_valid_i = 1'b0;
  logic [IW-1:0]    data_r_ID_i = '0;
  logic [NM-1:0]    data_r_valid_o;
  logic             idle_o;
  logic             resp_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  request_block_rr_pe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .N_MASTER(NM),
    .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO), .OUT_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
    .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_ID_o(data_ID_o),
    .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i), .data_r_ID_i(data_r_ID_i),
    .data_r_valid_o(data_r_valid_o), .idle_o(idle_o), .resp_err_o(resp_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  int            m_ptr;
  int            m_cnt [NM];
  bit            m_valid;
  logic [AW-1:0] m_add;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  int            m_id_idx;
  bit            m_idle;
  bit            m_err;
  bit            m_any;
  int            m_win;
  bit            m_take;
  logic [NM-1:0] exp_gnt;

  function automatic void model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_idle  = 1;
    m_err   = 0;
    for (int i = 0; i < NM; i++) m_cnt[i] = 0;
  endfunction

  // Expected combinational view for the inputs currently applied.
  function automatic void model_comb();
    m_any = 0;
    m_win = 0;
    for (int k = 0; k < NM; k++) begin
      int i;
      i = (m_ptr + k) % NM;
      if (!m_any && data_req_i[i] && m_cnt[i] < MAXO) begin
        m_any = 1;
        m_win = i;
      end
    end
    m_take  = rst_n && m_any && (!m_valid || data_gnt_i);
    exp_gnt = m_take ? NM'(1 << m_win) : '0;
  endfunction

  // State change at a rising edge for the inputs currently applied.
  function automatic void model_clock();
    bit any_cnt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_err = 0;
    for (int i = 0; i < NM; i++) begin
      bit rsp;
      bit req;
      rsp = data_r_valid_i && data_r_ID_i[i];
      req = m_take && (m_win == i);
      if (rsp && m_cnt[i] == 0) m_err = 1;
      if (req && !rsp) m_cnt[i] = m_cnt[i] + 1;
      else if (rsp && !req && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end
    if (m_take) begin
      m_valid  = 1;
      m_add    = data_add_i[m_win*AW +: AW];
      m_wen    = data_wen_i[m_win];
      m_wdata  = data_wdata_i[m_win*DW +: DW];
      m_be     = data_be_i[m_win*BW +: BW];
      m_id_idx = m_win;
      m_ptr    = (m_win + 1) % NM;
    end else if (data_gnt_i) begin
      m_valid = 0;
    end
    any_cnt = 0;
    for (int i = 0; i < NM; i++) if (m_cnt[i] != 0) any_cnt = 1;
    m_idle = !any_cnt && !m_valid;
  endfunction

  // ---------------- helpers (timing only) ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    data_req_i     = '0;
    data_gnt_i     = 1'b0;
    data_r_valid_i = 1'b0;
    data_r_ID_i    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n      = 1'b0;
    data_req_i = 3'b111;
    data_gnt_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (data_gnt_o !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", data_gnt_o); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle_o); end
    n_checks++;
    if (data_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", data_req_o); end
    n_checks++;
    if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err_o); end
    n_checks++;
    if (data_gnt_o !== 3'b000) begin n_fail++; $display("FAIL reset_gnt_held: got %b expected 000", data_gnt_o); end
    next_cycle();
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] g;
    logic [IW-1:0] id;
    do_reset();
    for (int i = 0; i < NM; i++) data_add_i[i*AW +: AW] = 32'hA000_0000 + i;
    data_req_i = 3'b111;
    data_gnt_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      // The slave answers each request in the cycle it accepts it.
      data_r_valid_i = (k >= 1);
      data_r_ID_i    = (k >= 1) ? IW'(1 << ((k - 1) % NM)) : '0;
      @(negedge clk);
      g = NM'(1 << (k % NM));
      n_checks++;
      if (data_gnt_o !== g) begin n_fail++; $display("FAIL rr_gnt k=%0d: got %b expected %b", k, data_gnt_o, g); end
      if (k >= 1) begin
        id = IW'(1 << ((k - 1) % NM));
        n_checks++;
        if (data_req_o !== 1'b1) begin n_fail++; $display("FAIL rr_req k=%0d: got %b expected 1", k, data_req_o); end
        n_checks++;
        if (data_ID_o !== id) begin n_fail++; $display("FAIL rr_id k=%0d: got %b expected %b", k, data_ID_o, id); end
        n_checks++;
        if (data_add_o !== 32'hA000_0000 + (k - 1) % NM) begin
          n_fail++; $display("FAIL rr_add k=%0d: got %h expected %h", k, data_add_o, 32'hA000_0000 + (k - 1) % NM);
        end
        n_checks++;
        if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL rr_err k=%0d: got %b expected 0", k, resp_err_o); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_outstanding_cap();
    logic [NM-1:0] exp_seq [8];
    logic [NM-1:0] req_seq [8];
    exp_seq = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    req_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b001, 3'b001, 3'b001};
    do_reset();
    data_gnt_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_req_i     = req_seq[k];
      data_r_valid_i = (k == 5);
      data_r_ID_i    = (k == 5) ? 3'b001 : 3'b000;
      @(negedge clk);
      n_checks++;
      if (data_gnt_o !== exp_seq[k]) begin
        n_fail++; $display("FAIL cap_gnt k=%0d: got %b expected %b", k, data_gnt_o, exp_seq[k]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < NM; i++) data_add_i[i*AW +: AW] = 32'hB000_0000 + i;
    data_req_i = 3'b111;
    data_gnt_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_gnt_o !== 3'b001) begin n_fail++; $display("FAIL bp_first_gnt: got %b expected 001", data_gnt_o); end
    next_cycle();
    // Inputs move while the slave stalls; the held entry must not.
    for (int i = 0; i < NM; i++) data_add_i[i*AW +: AW] = 32'hC000_0000 + i;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (data_gnt_o !== 3'b000) begin n_fail++; $display("FAIL bp_gnt k=%0d: got %b expected 000", k, data_gnt_o); end
      n_checks++;
      if (data_req_o !== 1'b1) begin n_fail++; $display("FAIL bp_req k=%0d: got %b expected 1", k, data_req_o); end
      n_checks++;
      if (data_add_o !== 32'hB000_0000) begin n_fail++; $display("FAIL bp_add k=%0d: got %h expected b0000000", k, data_add_o); end
      next_cycle();
    end
    data_gnt_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (data_gnt_o !== 3'b010) begin n_fail++; $display("FAIL bp_release_gnt: got %b expected 010", data_gnt_o); end
    n_checks++;
    if (data_add_o !== 32'hB000_0000) begin n_fail++; $display("FAIL bp_release_add: got %h expected b0000000", data_add_o); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (data_add_o !== 32'hC000_0001) begin n_fail++; $display("FAIL bp_next_add: got %h expected c0000001", data_add_o); end
    n_checks++;
    if (data_ID_o !== 3'b010) begin n_fail++; $display("FAIL bp_next_id: got %b expected 010", data_ID_o); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_unexpected_resp();
    do_reset();
    data_r_valid_i = 1'b1;
    data_r_ID_i    = 3'b010;
    @(negedge clk);
    n_checks++;
    if (data_r_valid_o !== 3'b010) begin n_fail++; $display("FAIL ur_route: got %b expected 010", data_r_valid_o); end
    n_checks++;
    if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL ur_err_early: got %b expected 0", resp_err_o); end
    next_cycle();
    data_r_valid_i = 1'b0;
    data_r_ID_i    = '0;
    @(negedge clk);
    n_checks++;
    if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL ur_err_pulse: got %b expected 1", resp_err_o); end
    n_checks++;
    if (idle_o !== 1'b1) begin n_fail++; $display("FAIL ur_idle: got %b expected 1", idle_o); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL ur_err_clear: got %b expected 0", resp_err_o); end
    next_cycle();
    // Counter for master 1 must still be zero: exactly two grants fit.
    data_req_i = 3'b010;
    data_gnt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (data_gnt_o !== ((k < 2) ? 3'b010 : 3'b000)) begin
        n_fail++; $display("FAIL ur_cnt_gnt k=%0d: got %b expected %b", k, data_gnt_o, (k < 2) ? 3'b010 : 3'b000);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_same_cycle_and_reset();
    logic [NM-1:0] exp_seq [6];
    logic [NM-1:0] req_seq [6];
    exp_seq = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b001, 3'b010};
    req_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b111, 3'b111};
    do_reset();
    data_gnt_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_req_i     = req_seq[k];
      data_r_valid_i = (k == 1);
      data_r_ID_i    = (k == 1) ? 3'b100 : 3'b000;
      @(negedge clk);
      n_checks++;
      if (data_gnt_o !== exp_seq[k]) begin
        n_fail++; $display("FAIL sc_gnt k=%0d: got %b expected %b", k, data_gnt_o, exp_seq[k]);
      end
      if (k == 2) begin
        n_checks++;
        if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL sc_err: got %b expected 0", resp_err_o); end
      end
      next_cycle();
    end
    // Reset in the middle of the burst.
    data_r_valid_i = 1'b0;
    data_r_ID_i    = '0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_gnt_o !== 3'b000) begin n_fail++; $display("FAIL mr_gnt_in_reset: got %b expected 000", data_gnt_o); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (idle_o !== 1'b1) begin n_fail++; $display("FAIL mr_idle: got %b expected 1", idle_o); end
    n_checks++;
    if (data_req_o !== 1'b0) begin n_fail++; $display("FAIL mr_req: got %b expected 0", data_req_o); end
    n_checks++;
    if (data_gnt_o !== 3'b001) begin n_fail++; $display("FAIL mr_first_gnt: got %b expected 001", data_gnt_o); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    int pick;
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n      = ($urandom_range(99) != 0);
      data_req_i = NM'($urandom);
      data_wen_i = NM'($urandom);
      for (int i = 0; i < NM; i++) begin
        data_add_i[i*AW +: AW]   = $urandom;
        data_wdata_i[i*DW +: DW] = $urandom;
        data_be_i[i*BW +: BW]    = BW'($urandom);
      end
      data_gnt_i     = ($urandom_range(3) != 0);
      data_r_valid_i = 1'b0;
      data_r_ID_i    = '0;
      pick = $urandom_range(NM - 1);
      if (m_cnt[pick] > 0 && $urandom_range(1) == 1) begin
        data_r_valid_i = 1'b1;
        data_r_ID_i    = IW'(1 << pick);
      end else if (m_cnt[pick] == 0 && !data_req_i[pick] && $urandom_range(7) == 0) begin
        data_r_valid_i = 1'b1;
        data_r_ID_i    = IW'(1 << pick);
      end
      model_comb();
      @(negedge clk);
      n_checks++;
      if (data_gnt_o !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt c=%0d: got %b expected %b", c, data_gnt_o, exp_gnt); end
      n_checks++;
      if (data_req_o !== m_valid) begin n_fail++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, data_req_o, m_valid); end
      n_checks++;
      if (data_r_valid_o !== (data_r_valid_i ? data_r_ID_i : 3'b000)) begin
        n_fail++; $display("FAIL rnd_rvalid c=%0d: got %b expected %b", c, data_r_valid_o, data_r_valid_i ? data_r_ID_i : 3'b000);
      end
      n_checks++;
      if (idle_o !== m_idle) begin n_fail++; $display("FAIL rnd_idle c=%0d: got %b expected %b", c, idle_o, m_idle); end
      n_checks++;
      if (resp_err_o !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d: got %b expected %b", c, resp_err_o, m_err); end
      if (m_valid) begin
        n_checks++;
        if (data_add_o !== m_add || data_wen_o !== m_wen || data_wdata_o !== m_wdata || data_be_o !== m_be) begin
          n_fail++;
          $display("FAIL rnd_payload c=%0d: got %h/%b/%h/%h expected %h/%b/%h/%h", c,
                   data_add_o, data_wen_o, data_wdata_o, data_be_o, m_add, m_wen, m_wdata, m_be);
        end
        n_checks++;
        if (data_ID_o !== IW'(1 << m_id_idx)) begin
          n_fail++; $display("FAIL rnd_id c=%0d: got %b expected %b", c, data_ID_o, IW'(1 << m_id_idx));
        end
      end
      @(posedge clk);
      model_clock();
      #1;
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding_cap();
    test_backpressure();
    test_unexpected_resp();
    test_same_cycle_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
